fifo_reader: RTL and testbench

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader_pkg.sv | 14 +
 rtl/fifo_reader_skid.sv | 49 ++++
 rtl/fifo_reader.sv | 96 +++++++++
 tb/tb_fifo_reader.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_reader_pkg.sv
// Shared defaults and state encoding for the burst FIFO reader.
package fifo_reader_pkg;

  localparam int RW_DEF = 8;
  localparam int LW_DEF = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry skid buffer: in-order storage for words read but not yet accepted downstream.
module fifo_reader_skid #(
  parameter int RW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [RW-1:0] din,
  input  logic          pop,
  output logic [1:0]    occ,
  output logic [RW-1:0] head
);

  logic [RW-1:0] e0;
  logic [RW-1:0] e1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ <= 2'd0;
      e0  <= '0;
      e1  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) e0 <= din;
          else             e1 <= din;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          occ <= occ - 2'd1;
        end
        // Simultaneous push and pop keeps occupancy; the new word lands behind the head.
        2'b11: begin
          if (occ == 2'd1) begin
            e0 <= din;
          end else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = (occ != 2'd0) ? e0 : '0;

endmodule

// File: rtl/fifo_reader.sv
// Burst reader: pulls ln words from a FIFO and streams them out over a valid/ready port.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int RW = RW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic          c,
  input  logic          re,
  input  logic          st,
  input  logic [LW-1:0] ln,
  input  logic          es,
  input  logic          uf,
  input  logic [RW-1:0] fd,
  output logic          rs,
  output logic          ov,
  input  logic          ordy,
  output logic [RW-1:0] od,
  output logic          bs,
  output logic          dn,
  output logic [LW-1:0] cnt,
  output logic          er,
  output state_t        dbg_state
);

  // Output handshake: a word moves on every cycle with ov=1 and ordy=1; while
  // ov=1 and ordy=0 the word on od is held unchanged; ov never drops without a transfer.

  state_t        state;
  logic [LW-1:0] len_q;
  logic [LW-1:0] issued;
  logic          inflight;
  logic [1:0]    occ;
  logic          xfer;
  logic [2:0]    pending;

  fifo_reader_skid #(.RW(RW)) u_skid (
    .clk   (c),
    .rst_n (re),
    .push  (inflight),
    .din   (fd),
    .pop   (xfer),
    .occ   (occ),
    .head  (od)
  );

  assign ov   = (occ != 2'd0);
  assign xfer = ov & ordy;

  // Words that will still need a buffer slot next cycle if no new read is issued.
  assign pending = {1'b0, occ} - {2'b00, xfer} + {2'b00, inflight};

  assign rs = (state == RUN) && !es && (issued < len_q) && (pending < 3'd2);

  assign bs        = (state != IDLE);
  assign dn        = (state == DONE);
  assign dbg_state = state;

  always_ff @(posedge c) begin
    if (!re) begin
      state    <= IDLE;
      len_q    <= '0;
      issued   <= '0;
      cnt      <= '0;
      inflight <= 1'b0;
      er       <= 1'b0;
    end else begin
      inflight <= rs;
      if (rs)   issued <= issued + 1'b1;
      if (xfer) cnt    <= cnt + 1'b1;
      if (uf || (rs && es)) er <= 1'b1;

      case (state)
        IDLE: begin
          if (st) begin
            len_q  <= ln;
            issued <= '0;
            cnt    <= '0;
            state  <= (ln == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (issued == len_q) state <= FLUSH;
        end
        FLUSH: begin
          if (cnt == len_q) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: FIFO model, output scoreboard and per-scenario tasks.
module tb_fifo_reader;
  import fifo_reader_pkg::*;

  localparam int RW = 8;
  localparam int LW = 6;

  logic          c    = 1'b0;
  logic          re   = 1'b0;
  logic          st   = 1'b0;
  logic [LW-1:0] ln   = '0;
  logic          es   = 1'b1;
  logic          uf   = 1'b0;
  logic [RW-1:0] fd   = '0;
  logic          ordy = 1'b0;
  logic          rs, ov, bs, dn, er;
  logic [RW-1:0] od;
  logic [LW-1:0] cnt;
  state_t        dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int n_xfer  = 0;
  int pend    = 0;

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] fifo_q[$];
  bit            held = 0;
  logic [RW-1:0] held_od = '0;

  always #5 c = ~c;

  fifo_reader #(.RW(RW), .LW(LW)) dut (
    .c(c), .re(re), .st(st), .ln(ln), .es(es), .uf(uf), .fd(fd),
    .rs(rs), .ov(ov), .ordy(ordy), .od(od), .bs(bs), .dn(dn),
    .cnt(cnt), .er(er), .dbg_state(dbg_state)
  );

  // FIFO model: rs seen mid-cycle is the read taken at the next edge; data follows one cycle later.
  initial begin : fifo_model
    bit rs_s;
    forever begin
      @(negedge c);
      rs_s = (rs === 1'b1);
      @(posedge c);
      #1;
      if (rs_s) begin
        n_tests++;
        if (fifo_q.size() == 0) begin
          n_fail++;
          $display("FAIL rs_while_empty: rs=1 seen while es=1");
        end else begin
          fd = fifo_q.pop_front();
        end
      end
      es = (fifo_q.size() == 0);
    end
  end

  // Scoreboard and handshake monitor.
  always @(negedge c) begin : monitor
    logic [RW-1:0] e;
    bit xf;
    if (re !== 1'b1) begin
      exp_q.delete();
      pend = 0;
      held = 0;
    end else begin
      xf = (ov === 1'b1) && (ordy === 1'b1);
      if (held) begin
        n_tests++;
        if (ov !== 1'b1 || od !== held_od) begin
          n_fail++;
          $display("FAIL stall_hold: ov=%b od=%0h required ov=1 od=%0h", ov, od, held_od);
        end
      end
      if (xf) begin
        n_tests++;
        n_xfer++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_word: od=%0h with no word expected", od);
        end else begin
          e = exp_q.pop_front();
          if (od !== e) begin
            n_fail++;
            $display("FAIL data_order: od=%0h required %0h", od, e);
          end
        end
      end
      if (rs === 1'b1) begin
        n_tests++;
        if (pend - (xf ? 1 : 0) >= 2) begin
          n_fail++;
          $display("FAIL rs_overcommit: rs=1 with %0d words pending, required <2", pend - (xf ? 1 : 0));
        end
      end
      pend = pend + ((rs === 1'b1) ? 1 : 0) - (xf ? 1 : 0);
      held = (ov === 1'b1) && (ordy !== 1'b1);
      held_od = od;
    end
  end

  task automatic start_burst(input logic [LW-1:0] len);
    @(posedge c); #1;
    st = 1'b1;
    ln = len;
    @(posedge c); #1;
    st = 1'b0;
    ln = LW'($urandom);
  endtask

  task automatic wait_done(input int budget, input bit toggle_ordy);
    bit seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge c);
      if (dn === 1'b1) seen = 1;
      else if (toggle_ordy) begin
        @(posedge c); #1;
        ordy = ~ordy;
      end
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL done_timeout: dn not seen within %0d cycles", budget);
    end
    @(negedge c);
    n_tests++;
    if (dn !== 1'b0 || bs !== 1'b0 || dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL done_pulse: dn=%b bs=%b state=%0d required 0 0 0", dn, bs, dbg_state);
    end
    #1;
  endtask

  task automatic test_reset;
    re = 1'b0;
    repeat (2) @(posedge c);
    #1 re = 1'b1;
    @(negedge c);
    n_tests++;
    if ({rs, ov, bs, dn, er} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: rs,ov,bs,dn,er=%b required 00000", {rs, ov, bs, dn, er});
    end
    n_tests++;
    if (od !== '0 || cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_data: od=%0h cnt=%0d required 0 0", od, cnt);
    end
    n_tests++;
    if (dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d required %0d", dbg_state, IDLE);
    end
  endtask

  task automatic test_full_burst;
    int n0;
    ordy = 1'b1;
    for (int i = 0; i < 32; i++) begin
      fifo_q.push_back(RW'(i));
      exp_q.push_back(RW'(i));
    end
    n0 = n_xfer;
    start_burst(6'd32);
    @(negedge c);
    n_tests++;
    if (ov !== 1'b0) begin n_fail++; $display("FAIL latency_e0: ov=%b required 0", ov); end
    @(negedge c);
    n_tests++;
    if (ov !== 1'b0) begin n_fail++; $display("FAIL latency_e1: ov=%b required 0", ov); end
    @(negedge c);
    n_tests++;
    if (ov !== 1'b1 || od !== 8'h00) begin
      n_fail++;
      $display("FAIL latency_e2: ov=%b od=%0h required 1 0", ov, od);
    end
    @(posedge c);
    repeat (31) @(posedge c);
    #1;
    n_tests++;
    if (n_xfer - n0 != 32) begin
      n_fail++;
      $display("FAIL throughput: %0d words in 32 cycles required 32", n_xfer - n0);
    end
    wait_done(20, 1'b0);
    n_tests++;
    if (cnt !== 6'd32 || exp_q.size() != 0 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL full_end: cnt=%0d left=%0d er=%b required 32 0 0", cnt, exp_q.size(), er);
    end
  endtask

  task automatic test_stall;
    int n0;
    logic [RW-1:0] w;
    for (int i = 0; i < 8; i++) begin
      w = RW'($urandom_range(0, 255));
      fifo_q.push_back(w);
      exp_q.push_back(w);
    end
    ordy = 1'b1;
    n0 = n_xfer;
    start_burst(6'd8);
    wait_done(100, 1'b1);
    ordy = 1'b1;
    n_tests++;
    if (n_xfer - n0 != 8 || cnt !== 6'd8 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stall_end: words=%0d cnt=%0d left=%0d required 8 8 0", n_xfer - n0, cnt, exp_q.size());
    end
  endtask

  task automatic test_empty_stall;
    int rs_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      fifo_q.push_back(RW'(8'hA0 + i));
      exp_q.push_back(RW'(8'hA0 + i));
    end
    ordy = 1'b1;
    start_burst(6'd4);
    repeat (10) begin
      @(negedge c);
      if (rs === 1'b1) rs_cnt++;
    end
    n_tests++;
    if (rs_cnt != 2) begin
      n_fail++;
      $display("FAIL empty_pause: %0d reads during pause required 2", rs_cnt);
    end
    for (int i = 2; i < 4; i++) begin
      fifo_q.push_back(RW'(8'hA0 + i));
      exp_q.push_back(RW'(8'hA0 + i));
    end
    wait_done(30, 1'b0);
    n_tests++;
    if (cnt !== 6'd4 || er !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL empty_end: cnt=%0d er=%b left=%0d required 4 0 0", cnt, er, exp_q.size());
    end
  endtask

  task automatic test_zero_len;
    fifo_q.push_back(8'h55);
    start_burst(6'd0);
    @(negedge c);
    n_tests++;
    if (dn !== 1'b1 || rs !== 1'b0 || cnt !== '0) begin
      n_fail++;
      $display("FAIL zero_done: dn=%b rs=%b cnt=%0d required 1 0 0", dn, rs, cnt);
    end
    @(negedge c);
    n_tests++;
    if (dn !== 1'b0 || bs !== 1'b0 || rs !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_after: dn=%b bs=%b rs=%b required 0 0 0", dn, bs, rs);
    end
    fifo_q.delete();
    repeat (2) @(posedge c);
    #1;
  endtask

  task automatic test_reset_mid;
    int n0;
    int stale = 0;
    bit got = 0;
    for (int i = 0; i < 8; i++) begin
      fifo_q.push_back(RW'(8'h10 + i));
      exp_q.push_back(RW'(8'h10 + i));
    end
    ordy = 1'b1;
    n0 = n_xfer;
    start_burst(6'd8);
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge c); #1;
      if (n_xfer - n0 >= 3) got = 1;
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL mid_timeout: %0d words delivered required 3", n_xfer - n0);
    end
    re = 1'b0;
    @(posedge c); #1;
    re = 1'b1;
    @(negedge c);
    n_tests++;
    if ({rs, ov, bs, dn, er} !== 5'b0 || od !== '0 || cnt !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: rs,ov,bs,dn,er=%b od=%0h cnt=%0d required 00000 0 0",
               {rs, ov, bs, dn, er}, od, cnt);
    end
    repeat (15) begin
      @(negedge c);
      if (ov !== 1'b0 || rs !== 1'b0) stale++;
    end
    n_tests++;
    if (stale != 0) begin
      n_fail++;
      $display("FAIL mid_stale: %0d cycles with ov or rs set required 0", stale);
    end
    fifo_q.delete();
    repeat (2) @(posedge c);
    #1;
  endtask

  task automatic test_underflow;
    n_tests++;
    if (er !== 1'b0) begin n_fail++; $display("FAIL uf_pre: er=%b required 0", er); end
    @(posedge c); #1 uf = 1'b1;
    @(posedge c); #1 uf = 1'b0;
    @(negedge c);
    n_tests++;
    if (er !== 1'b1) begin n_fail++; $display("FAIL uf_set: er=%b required 1", er); end
    repeat (5) @(negedge c);
    n_tests++;
    if (er !== 1'b1) begin n_fail++; $display("FAIL uf_sticky: er=%b required 1", er); end
    @(posedge c); #1 re = 1'b0;
    @(posedge c); #1 re = 1'b1;
    @(negedge c);
    n_tests++;
    if (er !== 1'b0) begin n_fail++; $display("FAIL uf_clear: er=%b required 0", er); end
  endtask

  initial begin
    test_reset();
    test_full_burst();
    test_stall();
    test_empty_stall();
    test_zero_len();
    test_reset_mid();
    test_underflow();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
